// File: rtl/sub_serial_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
// master drives operands and out_ready; slave returns in_ready, diff and bout.
interface sub_serial_if #(
   parameter int W = 16
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout
   );
endinterface

// File: rtl/sub_serial.sv
// Digit-serial a - b - bin, D bits per cycle LSB first; result valid N=W/D edges after accept.
// Accepts only in IDLE, holds diff/bout in DONE until out_ready; DONE->IDLE costs one cycle.
module sub_serial #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst,
   sub_serial_if.slave  bus
);
   localparam int N  = W / D;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  diff_q, diff_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          br_q, br_d;
   logic          bout_q, bout_d;
   logic [D:0]    dig;

   // One extra bit so the MSB of the digit result is the outgoing borrow.
   assign dig = {1'b0, a_q[D-1:0]} - {1'b0, b_q[D-1:0]} - {{D{1'b0}}, br_q};

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      cnt_d   = cnt_q;
      br_d    = br_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               br_d    = bus.bin;
               diff_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < N; k++) begin
               if (cnt_q == CW'(k)) diff_d[k*D +: D] = dig[D-1:0];
            end
            br_d  = dig[D];
            a_d   = a_q >> D;
            b_d   = b_q >> D;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               bout_d  = dig[D];
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         cnt_q   <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         cnt_q   <= cnt_d;
         br_q    <= br_d;
         bout_q  <= bout_d;
      end
   end
endmodule

// File: tb/tb_sub_serial.sv
// Directed and random operations on sub_serial checked against a whole-word arithmetic model.
module tb_sub_serial;
   localparam int W = 16;
   localparam int D = 4;
   localparam int N = W / D;

   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sub_serial_if #(.W(W)) bus();
   sub_serial #(.W(W), .D(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: whole-word unsigned arithmetic, borrow = a < b + bin.
   function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv,
                                              input logic bi);
      int r;
      r = int'(av) - int'(bv) - int'(bi);
      return W'(r & ((1 << W) - 1));
   endfunction

   function automatic logic ref_bout(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic bi);
      return (int'(av) < int'(bv) + int'(bi));
   endfunction

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         input int hold);
      logic [W-1:0] ed;
      logic         eb;
      int           lat;
      ed = ref_diff(av, bv, bi);
      eb = ref_bout(av, bv, bi);
      @(negedge clk);
      check("in_ready_idle", bus.in_ready, 1);
      bus.a = av;
      bus.b = bv;
      bus.bin = bi;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      @(posedge clk);
      #1;
      // Keep in_valid high with junk operands: must be ignored outside IDLE.
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      bus.bin = 1'($urandom);
      @(negedge clk);
      check("in_ready_run", bus.in_ready, 0);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", lat, N);
      check("diff", bus.diff, ed);
      check("bout", bus.bout, eb);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_out_valid", bus.out_valid, 1);
         check("hold_in_ready", bus.in_ready, 0);
         check("hold_diff", bus.diff, ed);
         check("hold_bout", bus.bout, eb);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_out_valid", bus.out_valid, 0);
      check("release_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b0;
   endtask

   logic [W:0]   exp_q[$];
   int           acc_q[$];
   logic [W-1:0] ba[3];
   logic [W-1:0] bb[3];
   logic         bbi[3];
   logic [W:0]   e;
   int           got;
   int           idx;
   bit           acc;
   int           ov_seen;

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_bout", bus.bout, 0);

      run_op(16'h1234, 16'h0234, 1'b0, 0);
      run_op(16'h1000, 16'h0001, 1'b0, 0);
      run_op(16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h8000, 1'b1, 0);
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1);
      run_op(16'h00FF, 16'h00FF, 1'b0, 0);
      run_op(16'hA5C3, 16'h5A3C, 1'b1, 5);

      // Reset during the second RUN cycle discards the operation.
      @(negedge clk);
      bus.a = 16'h1234;
      bus.b = 16'h4321;
      bus.bin = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_diff", bus.diff, 0);
      check("midrst_bout", bus.bout, 0);
      ov_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) ov_seen++;
      end
      check("midrst_no_pulse", ov_seen, 0);
      run_op(16'h0005, 16'h0003, 1'b0, 0);

      for (int r = 0; r < 20; r++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      end

      // Back-to-back with out_ready tied high.
      for (int i = 0; i < 3; i++) begin
         ba[i]  = W'($urandom);
         bb[i]  = W'($urandom);
         bbi[i] = 1'($urandom);
      end
      ba[1] = 16'h0000;
      bb[1] = 16'hFFFF;
      @(negedge clk);
      idx = 0;
      got = 0;
      bus.a = ba[0];
      bus.b = bb[0];
      bus.bin = bbi[0];
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      for (int t = 0; t < 80 && got < 3; t++) begin
         if (t > 0) @(negedge clk);
         if (bus.out_valid) begin
            check("b2b_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("b2b_diff", bus.diff, e[W-1:0]);
               check("b2b_bout", bus.bout, e[W]);
            end
            got++;
         end
         acc = bus.in_ready && bus.in_valid;
         if (acc) begin
            exp_q.push_back({ref_bout(ba[idx], bb[idx], bbi[idx]),
                             ref_diff(ba[idx], bb[idx], bbi[idx])});
            acc_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         if (acc) begin
            idx++;
            if (idx < 3) begin
               bus.a = ba[idx];
               bus.b = bb[idx];
               bus.bin = bbi[idx];
            end else begin
               bus.in_valid = 1'b0;
            end
         end
      end
      bus.in_valid = 1'b0;
      check("b2b_results", got, 3);
      check("b2b_accepts", acc_q.size(), 3);
      if (acc_q.size() == 3) begin
         check("b2b_ii_0", acc_q[1] - acc_q[0], N + 2);
         check("b2b_ii_1", acc_q[2] - acc_q[1], N + 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
